channel_arbiter: RTL and testbench
==================================

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter NUM_OF_CONTROL_SIGNALS, default 2, select width; number of channels N = 2**NUM_OF_CONTROL_SIGNALS.
REQ-002 Parameter BURST_LENGTH, default 4, maximum accepted transfers per grant; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 request  input  N  per-channel request; bit i high = channel i has data.
REQ-006 out_ready  input  1  downstream (multiplexer consumer) accepts a transfer this cycle.
REQ-007 control_signals  output  NUM_OF_CONTROL_SIGNALS  binary index of granted channel; drives the multiplexer select.
REQ-008 grant  output  N  one-hot grant; all-zero when no grant is held.
REQ-009 out_valid  output  1  granted channel is presenting data this cycle.
REQ-010 in_ready  output  N  per-channel ready back to the sources.

Function
REQ-011 The block SHALL implement two states: IDLE and BUSY.
REQ-012 In IDLE, grant, out_valid and in_ready SHALL be all-zero; control_signals SHALL hold its last value.
REQ-013 In IDLE with any request bit high, the block SHALL choose the first requesting channel searching circularly from (last_sel+1) mod N, register it into control_signals and grant, and enter BUSY on the next edge (one-cycle arbitration latency).
REQ-014 last_sel SHALL update to the chosen index on every new grant.
REQ-015 In BUSY: out_valid = request[control_signals]; in_ready[i] = grant[i] AND out_ready; transfer = out_valid AND out_ready.
REQ-016 The burst counter, width $clog2(BURST_LENGTH+1), SHALL clear on every new grant and increment by 1 on each transfer.
REQ-017 The counter SHALL hold while out_ready is low; control_signals and grant SHALL be stable for the whole of BUSY.
REQ-018 BUSY SHALL release to IDLE on the edge where a transfer occurs with count == BURST_LENGTH-1.
REQ-019 BUSY SHALL also release to IDLE on the edge where request[control_signals] is sampled low, regardless of count.
REQ-020 Release SHALL always pass through exactly one IDLE cycle, the switch-settling gap, before the next grant.
REQ-021 A sole requester SHALL be re-granted after the gap; non-granted requests SHALL never be lost and SHALL be served within N grants.
REQ-022 Changes on non-granted request bits SHALL NOT affect the current grant.
REQ-023 With BURST_LENGTH = 1, each grant SHALL cover exactly one transfer.

Reset
REQ-024 On reset high at an edge: state = IDLE, grant = 0, out_valid = 0, in_ready = 0, control_signals = 0, count = 0, last_sel = N-1, so the first search starts at channel 0.
REQ-025 Reset SHALL take priority over all other events, including mid-burst and simultaneous transfer or release.

Verification (N=4, BURST_LENGTH=4)
REQ-026 Reset applied, then request=4'b0100 -> all outputs 0 during reset; 1 cycle after arbitration: control_signals=2, grant=4'b0100, out_valid=1.
REQ-027 request=4'b1111, out_ready=1 held -> grants to channels 0,1,2,3,0 in that order; each grant lasts 4 transfer cycles with 1 IDLE cycle between grants.
REQ-028 Channel 1 granted, out_ready low for 3 cycles after transfer 2 -> count holds at 2, in_ready=0, control_signals=1 stable; release follows exactly 2 further transfers.
REQ-029 Channel 3 granted, request[3] drops after 2 transfers with request[0] high -> IDLE next edge, then channel 0 granted.
REQ-030 Reset mid-burst on channel 2, then request=4'b1001 -> outputs cleared next edge; channel 0 granted first (last_sel reset to 3).
REQ-031 Only request[1] held high for 12 cycles, out_ready=1 -> channel 1 granted repeatedly, 4 transfers per grant, 1 IDLE gap each time.

Source files
------------

// File: rtl/channel_arbiter.sv
// Round-robin channel arbiter driving a multiplexer select.
// Grants are held for up to BURST_LENGTH transfers.
module channel_arbiter #(
  parameter int NUM_OF_CONTROL_SIGNALS = 2,
  parameter int BURST_LENGTH = 4,
  localparam int S = NUM_OF_CONTROL_SIGNALS,
  localparam int N = 2**NUM_OF_CONTROL_SIGNALS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  input  logic         out_ready,
  output logic [S-1:0] control_signals,
  output logic [N-1:0] grant,
  output logic         out_valid,
  output logic [N-1:0] in_ready
);

  localparam int CW = $clog2(BURST_LENGTH + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [S-1:0]    last_sel;
  logic [S-1:0]    pick;
  logic [S-1:0]    idx;
  logic            found;
  logic [CW-1:0]   count;
  logic            hold_req;
  logic            xfer;
  logic            at_end;
  logic            release_now;

  assign hold_req    = request[control_signals];
  assign out_valid   = (state == BUSY) & hold_req;
  assign xfer        = out_valid & out_ready;
  assign at_end      = count == CW'(BURST_LENGTH - 1);
  assign release_now = (state == BUSY) &
                       (~hold_req | (xfer & at_end));
  assign in_ready    = grant & {N{out_ready}};

  // circular search for the next requester after last_sel
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = last_sel + S'(k);
      if (!found && request[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (found)       state_nxt = BUSY;
      BUSY: if (release_now) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // grant, select and burst counter
  always_ff @(posedge clk) begin
    if (reset) begin
      control_signals <= '0;
      last_sel        <= S'(N - 1);
      grant           <= '0;
      count           <= '0;
    end else if (state == IDLE && found) begin
      control_signals <= pick;
      last_sel        <= pick;
      grant           <= N'(1) << pick;
      count           <= '0;
    end else if (release_now) begin
      grant           <= '0;
    end else if (xfer) begin
      count           <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// Bench for channel_arbiter: burst 4 and burst 1 instances
// checked cycle by cycle against a transaction-level model.
module tb_channel_arbiter;

  localparam int S = 2;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic         out_ready;

  logic [S-1:0] cs0, cs1;
  logic [N-1:0] g0, g1, ir0, ir1;
  logic         ov0, ov1;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;
  bit rec    = 0;
  logic [N-1:0] pg = '0;
  int gq[$];

  int owner[2];
  int beats[2];
  int last[2];
  int mcs[2];
  int bl[2] = '{4, 1};

  always #5 clk = ~clk;

  channel_arbiter #(
    .NUM_OF_CONTROL_SIGNALS(S),
    .BURST_LENGTH(4)
  ) dut0 (
    .clk(clk), .reset(reset), .request(request),
    .out_ready(out_ready), .control_signals(cs0),
    .grant(g0), .out_valid(ov0), .in_ready(ir0)
  );

  channel_arbiter #(
    .NUM_OF_CONTROL_SIGNALS(S),
    .BURST_LENGTH(1)
  ) dut1 (
    .clk(clk), .reset(reset), .request(request),
    .out_ready(out_ready), .control_signals(cs1),
    .grant(g1), .out_valid(ov1), .in_ready(ir1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         ev;
    for (int d = 0; d < 2; d++) begin
      eg = (owner[d] >= 0) ? N'(1 << owner[d]) : '0;
      ev = (owner[d] >= 0) && request[owner[d]];
      er = out_ready ? eg : '0;
      chk($sformatf("grant%0d", d),
          d ? g1 : g0, eg);
      chk($sformatf("sel%0d", d),
          d ? cs1 : cs0, mcs[d]);
      chk($sformatf("valid%0d", d),
          d ? ov1 : ov0, ev);
      chk($sformatf("inrdy%0d", d),
          d ? ir1 : ir0, er);
    end
  endtask

  task automatic model_update();
    int c;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        owner[d] = -1;
        beats[d] = 0;
        last[d]  = N - 1;
        mcs[d]   = 0;
      end else if (owner[d] < 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (last[d] + k) % N;
          if (owner[d] < 0 && request[c]) begin
            owner[d] = c;
            last[d]  = c;
            mcs[d]   = c;
            beats[d] = 0;
          end
        end
      end else if (!request[owner[d]]) begin
        owner[d] = -1;
      end else if (out_ready) begin
        beats[d]++;
        if (beats[d] == bl[d]) owner[d] = -1;
      end
    end
  endtask

  task automatic step(input logic rst,
                      input logic [N-1:0] rq,
                      input logic ordy);
    @(negedge clk);
    reset     = rst;
    request   = rq;
    out_ready = ordy;
    #1;
    if (armed) compare_all();
    if (rec && g0 != 0 && pg == 0) gq.push_back(int'(cs0));
    pg = g0;
    @(posedge clk);
    model_update();
    armed = 1;
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, '0, 1'b1);
    step(1'b1, '0, 1'b1);
  endtask

  logic [N-1:0] rq;
  logic         ordy;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset     = 1'b1;
    request   = '0;
    out_ready = 1'b0;

    // reset, then single request for channel 2
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    chk("r026_sel", cs0, 2);
    chk("r026_grant", g0, 4'b0100);
    chk("r026_valid", ov0, 1'b1);

    // all channels requesting: round-robin order
    do_reset();
    rec = 1;
    for (int i = 0; i < 26; i++) step(1'b0, 4'b1111, 1'b1);
    rec = 0;
    chk("r027_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk($sformatf("r027_order%0d", i), gq[i], exp_order[i]);

    // out_ready stall mid-burst on channel 1
    do_reset();
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    repeat (3) step(1'b0, 4'b0010, 1'b0);
    repeat (4) step(1'b0, 4'b0010, 1'b1);

    // channel 3 drops request, channel 0 waiting
    do_reset();
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b1001, 1'b1);
    step(1'b0, 4'b1001, 1'b1);
    repeat (4) step(1'b0, 4'b0001, 1'b1);

    // reset in the middle of a burst
    do_reset();
    repeat (3) step(1'b0, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    repeat (3) step(1'b0, 4'b1001, 1'b1);
    chk("r030_sel", cs0, 0);

    // sole requester re-granted after each gap
    do_reset();
    repeat (12) step(1'b0, 4'b0010, 1'b1);

    // random traffic
    do_reset();
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) rq = N'($urandom);
      ordy = $urandom_range(3) != 0;
      step($urandom_range(199) == 0, rq, ordy);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
